// File: rtl/ysyx_22050710_ifu.sv
// Instruction fetch unit: holds the architectural PC, fetches one instruction at a time
// over a valid/ready memory interface, and hands {inst, pc} to decode.
// Optional build macro YSYX_22050710_IFU_MISALIGN_CHECK_EN traps misaligned next PCs.
module ysyx_22050710_ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          INST_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [63:0]       i_nextpc,
  input  logic              i_nextpc_valid,
  output logic              o_imem_req_valid,
  output logic [63:0]       o_imem_addr,
  input  logic              i_imem_req_ready,
  input  logic              i_imem_rsp_valid,
  input  logic [INST_W-1:0] i_imem_rsp_data,
  input  logic              i_imem_rsp_err,
  output logic              o_imem_rsp_ready,
  output logic [INST_W-1:0] o_inst,
  output logic [63:0]       o_pc,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic              o_fetch_err,
  output logic [63:0]       o_fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_EXEC,
    S_ERR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] pc;
  logic [63:0] pc_next;
  logic        rsp_accept;
  logic        inst_accept;

`ifndef YSYX_22050710_IFU_MISALIGN_CHECK_EN
  // Low PC bits are simply dropped when misalignment is not trapped.
  logic nextpc_unused;
  assign nextpc_unused = ^i_nextpc[1:0];
`endif

  assign rsp_accept  = (state == S_WAIT) && i_imem_rsp_valid;
  assign inst_accept = (state == S_VALID) && i_inst_ready;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      S_IDLE:  state_next = S_REQ;
      S_REQ:   if (i_imem_req_ready) state_next = S_WAIT;
      S_WAIT: begin
        if (i_imem_rsp_valid) state_next = i_imem_rsp_err ? S_ERR : S_VALID;
      end
      S_VALID: if (i_inst_ready) state_next = S_EXEC;
      S_EXEC: begin
        if (i_nextpc_valid) begin
`ifdef YSYX_22050710_IFU_MISALIGN_CHECK_EN
          if (i_nextpc[1:0] != 2'b00) begin
            state_next = S_ERR;
          end else begin
            pc_next    = i_nextpc;
            state_next = S_REQ;
          end
`else
          pc_next    = {i_nextpc[63:2], 2'b00};
          state_next = S_REQ;
`endif
        end
      end
      S_ERR:   state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Decode-side payload is captured only on a clean response and held until consumed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_inst <= '0;
      o_pc   <= '0;
    end else if (rsp_accept && !i_imem_rsp_err) begin
      o_inst <= i_imem_rsp_data;
      o_pc   <= pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fetch_cnt <= '0;
    end else if (inst_accept) begin
      o_fetch_cnt <= o_fetch_cnt + 64'd1;
    end
  end

  assign o_imem_addr      = pc;
  assign o_imem_req_valid = (state == S_REQ);
  assign o_imem_rsp_ready = (state == S_WAIT);
  assign o_inst_valid     = (state == S_VALID);
  assign o_fetch_err      = (state == S_ERR);

endmodule

// File: tb/tb_ysyx_22050710_ifu.sv
// Randomized bench for ysyx_22050710_ifu: plays memory, decode and execute, and checks
// each fetch transaction against a transaction-level model of PC, count and fault state.
module tb_ysyx_22050710_ifu;

`ifdef YSYX_22050710_IFU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic [63:0] i_nextpc;
  logic        i_nextpc_valid;
  logic        o_imem_req_valid;
  logic [63:0] o_imem_addr;
  logic        i_imem_req_ready;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_imem_rsp_err;
  logic        o_imem_rsp_ready;
  logic [31:0] o_inst;
  logic [63:0] o_pc;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic        o_fetch_err;
  logic [63:0] o_fetch_cnt;

  int total = 0;
  int bad   = 0;

  logic [63:0] model_pc;
  logic [63:0] model_cnt;
  logic        model_err;

  ysyx_22050710_ifu #(.RESET_PC(RESET_PC), .INST_W(32)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_nextpc         (i_nextpc),
    .i_nextpc_valid   (i_nextpc_valid),
    .o_imem_req_valid (o_imem_req_valid),
    .o_imem_addr      (o_imem_addr),
    .i_imem_req_ready (i_imem_req_ready),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_imem_rsp_err   (i_imem_rsp_err),
    .o_imem_rsp_ready (o_imem_rsp_ready),
    .o_inst           (o_inst),
    .o_pc             (o_pc),
    .o_inst_valid     (o_inst_valid),
    .i_inst_ready     (i_inst_ready),
    .o_fetch_err      (o_fetch_err),
    .o_fetch_cnt      (o_fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_req"},   64'(o_imem_req_valid), 64'd0);
    checkOutput({tag, "_rsprd"}, 64'(o_imem_rsp_ready), 64'd0);
    checkOutput({tag, "_ivld"},  64'(o_inst_valid),     64'd0);
    checkOutput({tag, "_inst"},  64'(o_inst),           64'd0);
    checkOutput({tag, "_err"},   64'(o_fetch_err),      64'd0);
    checkOutput({tag, "_cnt"},   o_fetch_cnt,           64'd0);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic doReset();
    i_nextpc_valid   = 1'b0;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_err   = 1'b0;
    i_inst_ready     = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkIdleOutputs("rst_async");
    checkOutput("rst_addr", o_imem_addr, RESET_PC);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    model_pc  = RESET_PC;
    model_cnt = 64'd0;
    model_err = 1'b0;
    @(negedge clk);
    checkOutput("req_after_reset", 64'(o_imem_req_valid), 64'd1);
  endtask

  // Sticky fault: nothing the environment does may produce further activity.
  task automatic checkSticky();
    for (int i = 0; i < 4; i++) begin
      i_imem_req_ready = 1'b1;
      i_imem_rsp_valid = 1'b1;
      i_nextpc_valid   = 1'b1;
      i_inst_ready     = 1'b1;
      @(negedge clk);
      checkOutput("err_sticky", 64'(o_fetch_err),      64'd1);
      checkOutput("err_noreq",  64'(o_imem_req_valid), 64'd0);
      checkOutput("err_noivld", 64'(o_inst_valid),     64'd0);
      checkOutput("err_norsp",  64'(o_imem_rsp_ready), 64'd0);
      checkOutput("err_cnt",    o_fetch_cnt,           model_cnt);
    end
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_nextpc_valid   = 1'b0;
    i_inst_ready     = 1'b0;
  endtask

  // One full fetch transaction; entered at a negedge where a request is expected.
  task automatic applyStimulus(input logic [31:0] data, input int req_wait, input int rsp_wait,
                               input int idu_wait, input logic err, input logic [63:0] nextpc);
    int n = 0;
    while (!o_imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_seen", 64'(o_imem_req_valid), 64'd1);
    if (!o_imem_req_valid) return;
    checkOutput("req_addr", o_imem_addr, model_pc);
    checkOutput("req_norsp", 64'(o_imem_rsp_ready), 64'd0);
    for (int i = 0; i < req_wait; i++) begin
      i_imem_req_ready = 1'b0;
      i_imem_rsp_valid = 1'($urandom_range(0, 1));
      i_imem_rsp_data  = $urandom;
      @(negedge clk);
      checkOutput("req_hold",  64'(o_imem_req_valid), 64'd1);
      checkOutput("addr_hold", o_imem_addr, model_pc);
      checkOutput("req_norsp", 64'(o_imem_rsp_ready), 64'd0);
    end
    i_imem_rsp_valid = 1'b0;
    i_imem_req_ready = 1'b1;
    @(negedge clk);
    i_imem_req_ready = 1'b0;
    checkOutput("wait_noreq", 64'(o_imem_req_valid), 64'd0);
    checkOutput("wait_rsprd", 64'(o_imem_rsp_ready), 64'd1);
    for (int i = 0; i < rsp_wait; i++) begin
      @(negedge clk);
      checkOutput("wait_rsprd", 64'(o_imem_rsp_ready), 64'd1);
      checkOutput("wait_noivld", 64'(o_inst_valid), 64'd0);
    end
    i_imem_rsp_valid = 1'b1;
    i_imem_rsp_data  = data;
    i_imem_rsp_err   = err;
    @(negedge clk);
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_err   = 1'b0;
    if (err) begin
      model_err = 1'b1;
      checkSticky();
      return;
    end
    checkOutput("ivld", 64'(o_inst_valid), 64'd1);
    checkOutput("inst", 64'(o_inst), 64'(data));
    checkOutput("ipc",  o_pc, model_pc);
    checkOutput("ivld_rsprd", 64'(o_imem_rsp_ready), 64'd0);
    for (int i = 0; i < idu_wait; i++) begin
      i_inst_ready   = 1'b0;
      i_nextpc_valid = 1'($urandom_range(0, 1));
      i_nextpc       = {$urandom, $urandom};
      @(negedge clk);
      checkOutput("ivld_hold", 64'(o_inst_valid), 64'd1);
      checkOutput("inst_hold", 64'(o_inst), 64'(data));
      checkOutput("ipc_hold",  o_pc, model_pc);
      checkOutput("cnt_hold",  o_fetch_cnt, model_cnt);
      checkOutput("ivld_noreq", 64'(o_imem_req_valid), 64'd0);
    end
    i_nextpc_valid = 1'b0;
    i_inst_ready   = 1'b1;
    @(negedge clk);
    i_inst_ready = 1'b0;
    model_cnt    = model_cnt + 64'd1;
    checkOutput("exec_noivld", 64'(o_inst_valid), 64'd0);
    checkOutput("cnt", o_fetch_cnt, model_cnt);
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("exec_noreq", 64'(o_imem_req_valid), 64'd0);
    end
    i_nextpc       = nextpc;
    i_nextpc_valid = 1'b1;
    @(negedge clk);
    i_nextpc_valid = 1'b0;
    if (MIS_EN && nextpc[1:0] != 2'b00) begin
      checkOutput("mis_err",  64'(o_fetch_err), 64'd1);
      checkOutput("mis_pc",   o_imem_addr, model_pc);
      model_err = 1'b1;
      checkSticky();
    end else begin
      model_pc = {nextpc[63:2], 2'b00};
      checkOutput("retire_req",  64'(o_imem_req_valid), 64'd1);
      checkOutput("retire_addr", o_imem_addr, model_pc);
    end
  endtask

  initial begin
    rst_n            = 1'b1;
    i_nextpc         = '0;
    i_nextpc_valid   = 1'b0;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    i_imem_rsp_err   = 1'b0;
    i_inst_ready     = 1'b0;
    @(negedge clk);
    doReset();

    applyStimulus(32'h0000_0413, 0, 0, 0, 1'b0, 64'h8000_0004);
    applyStimulus(32'h1234_5678, 3, 0, 5, 1'b0, 64'h8000_0006);
    if (model_err) doReset();
    applyStimulus(32'hdead_beef, 0, 2, 5, 1'b1, 64'h8000_0008);
    doReset();

    // Reset while waiting on a response abandons the fetch.
    applyStimulus(32'h0000_0013, 0, 0, 0, 1'b0, 64'h8000_0100);
    i_imem_req_ready = 1'b1;
    @(negedge clk);
    i_imem_req_ready = 1'b0;
    checkOutput("midwait_rsprd", 64'(o_imem_rsp_ready), 64'd1);
    doReset();
    checkOutput("restart_addr", o_imem_addr, RESET_PC);

    for (int t = 0; t < 40; t++) begin
      logic [63:0] npc;
      npc = {32'h0, 32'h8000_0000 + ($urandom & 32'h000f_fffc)};
      if ($urandom_range(0, 3) == 0) npc[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) npc[63:32] = $urandom;
      applyStimulus($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom_range(0, 9) == 0), npc);
      if (model_err) doReset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
